// File: rtl/mem_xlate_pkg.sv
// Shared definitions for the memory translate/issue block: FSM state
// encoding, access size encoding, exception bit positions and the
// byte-lane helpers used when building the bus request.
package mem_xlate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XLATE = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // resp_exc = {ADEM, ALE, TLBR, PIL, PIS, PPI, PME}
    localparam int EXC_W    = 7;
    localparam int EXC_PME  = 0;
    localparam int EXC_PPI  = 1;
    localparam int EXC_PIS  = 2;
    localparam int EXC_PIL  = 3;
    localparam int EXC_TLBR = 4;
    localparam int EXC_ALE  = 5;
    localparam int EXC_ADEM = 6;

    // Byte strobes for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_strb = 4'b0001 << off;
            SZ_HALF: lane_strb = off[1] ? 4'b1100 : 4'b0011;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    // Right-aligned store data replicated onto every lane it could occupy.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_xlate_lookup.sv
// Address translation: direct mode, then lowest-index DMW hit, then TLB.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: va/store/size of the registered request, privilege and window
// config, TLB result flags; outputs physical address pa and exception vector exc.
module mem_xlate_lookup
    import mem_xlate_pkg::*;
#(
    parameter int DMW_NUM = 2
) (
    input  logic [31:0]          va,
    input  logic                 store,
    input  logic [1:0]           size,
    input  logic [1:0]           plv,
    input  logic                 direct_addr,
    input  logic [DMW_NUM*8-1:0] dmw_cfg,
    input  logic                 tlb_found,
    input  logic                 tlb_v,
    input  logic                 tlb_d,
    input  logic [19:0]          tlb_ppn,
    input  logic [5:0]           tlb_ps,
    input  logic [1:0]           tlb_plv,
    output logic [31:0]          pa,
    output logic [EXC_W-1:0]     exc
);

    logic       dmw_hit;
    logic [2:0] dmw_pseg;
    logic       ale;
    logic       adem;
    logic       tlb_chk;
    logic       tlb_ok;
    logic       ppi;

    // Window byte layout: {plv0, plv3, pseg[2:0], vseg[2:0]}.
    always_comb begin
        dmw_hit  = 1'b0;
        dmw_pseg = 3'b000;
        for (int i = 0; i < DMW_NUM; i++) begin
            if (!dmw_hit && va[31:29] == dmw_cfg[i*8 +: 3] &&
                ((plv == 2'd0 && dmw_cfg[i*8+7]) || (plv == 2'd3 && dmw_cfg[i*8+6]))) begin
                dmw_hit  = 1'b1;
                dmw_pseg = dmw_cfg[i*8+3 +: 3];
            end
        end
    end

    always_comb begin
        ale  = (size == SZ_WORD && va[1:0] != 2'b00) || (size == SZ_HALF && va[0]);
        adem = va[31] && plv == 2'd3 && !dmw_hit && !direct_addr;
        // TLB faults only matter when the TLB supplies the address and
        // the access has not already failed an address check.
        tlb_chk = !direct_addr && !dmw_hit && !ale && !adem;
        tlb_ok  = tlb_found && tlb_v;
        ppi     = tlb_chk && tlb_ok && (plv > tlb_plv);

        exc           = '0;
        exc[EXC_ADEM] = adem;
        exc[EXC_ALE]  = ale;
        exc[EXC_TLBR] = tlb_chk && !tlb_found;
        exc[EXC_PIL]  = tlb_chk && tlb_found && !tlb_v && !store;
        exc[EXC_PIS]  = tlb_chk && tlb_found && !tlb_v && store;
        exc[EXC_PPI]  = ppi;
        exc[EXC_PME]  = tlb_chk && tlb_ok && !ppi && store && !tlb_d;

        if (direct_addr)
            pa = va;
        else if (dmw_hit)
            pa = {dmw_pseg, va[28:0]};
        else if (tlb_ps == 6'd22)
            pa = {tlb_ppn[19:10], va[21:0]};
        else
            pa = {tlb_ppn, va[11:0]};
    end

endmodule

// File: rtl/mem_xlate_issue.sv
// Translate one load/store request and issue it to the data bus.
// Latency: accept -> 1 cycle XLATE -> ISSUE held until data_addr_ok.
// Backpressure: in_ready low unless IDLE, outstanding < MAX_OUTST, no flush.
// Ports: in_* request, flush/plv/direct_addr/dmw_cfg context, tlb_* lookup,
// data_* bus, resp_* result. MEM_XLATE_PERF_EN adds perf_tlb_miss/perf_stall.
module mem_xlate_issue
    import mem_xlate_pkg::*;
#(
    parameter int DMW_NUM   = 2,
    parameter int MAX_OUTST = 4,
    parameter int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_vaddr,
    input  logic                 in_store,
    input  logic [1:0]           in_size,
    input  logic [31:0]          in_wdata,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    input  logic [1:0]           plv,
    input  logic                 direct_addr,
    input  logic [DMW_NUM*8-1:0] dmw_cfg,
    output logic [18:0]          tlb_vppn,
    output logic                 tlb_va_bit12,
    input  logic                 tlb_found,
    input  logic                 tlb_v,
    input  logic                 tlb_d,
    input  logic [19:0]          tlb_ppn,
    input  logic [5:0]           tlb_ps,
    input  logic [1:0]           tlb_plv,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [1:0]           data_size,
    output logic [3:0]           data_wstrb,
    output logic [31:0]          data_addr,
    output logic [31:0]          data_wdata,
    input  logic                 data_addr_ok,
    input  logic                 data_data_ok,
    output logic                 resp_valid,
    output logic [TAG_W-1:0]     resp_tag,
    output logic [6:0]           resp_exc,
    output logic                 resp_issued
`ifdef MEM_XLATE_PERF_EN
    ,
    output logic [31:0]          perf_tlb_miss,
    output logic [31:0]          perf_stall
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    state_t             state_q, state_d;
    logic [31:0]        va_q, va_d;
    logic               store_q, store_d;
    logic [1:0]         size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         strb_q, strb_d;
    logic [31:0]        bdata_q, bdata_d;
    logic               inc, dec;
    logic [31:0]        pa;
    logic [EXC_W-1:0]   exc;

    mem_xlate_lookup #(.DMW_NUM(DMW_NUM)) u_lookup (
        .va          (va_q),
        .store       (store_q),
        .size        (size_q),
        .plv         (plv),
        .direct_addr (direct_addr),
        .dmw_cfg     (dmw_cfg),
        .tlb_found   (tlb_found),
        .tlb_v       (tlb_v),
        .tlb_d       (tlb_d),
        .tlb_ppn     (tlb_ppn),
        .tlb_ps      (tlb_ps),
        .tlb_plv     (tlb_plv),
        .pa          (pa),
        .exc         (exc)
    );

    always_comb begin
        state_d     = state_q;
        va_d        = va_q;
        store_d     = store_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        addr_d      = addr_q;
        strb_d      = strb_q;
        bdata_d     = bdata_q;
        inc         = 1'b0;
        resp_valid  = 1'b0;
        resp_issued = 1'b0;
        resp_exc    = '0;
        // Gated by reset so the request port is closed while reset is held.
        in_ready    = (state_q == ST_IDLE) && (cnt_q < CNT_W'(MAX_OUTST)) && !flush && !reset;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    va_d    = in_vaddr;
                    store_d = in_store;
                    size_d  = in_size;
                    wdata_d = in_wdata;
                    tag_d   = in_tag;
                    state_d = ST_XLATE;
                end
            end
            ST_XLATE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (|exc) begin
                    resp_valid = 1'b1;
                    resp_exc   = exc;
                    state_d    = ST_IDLE;
                end else begin
                    addr_d  = pa;
                    strb_d  = lane_strb(size_q, va_q[1:0]);
                    bdata_d = lane_data(size_q, wdata_q);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A flush coinciding with addr_ok still counts the request
                // but suppresses its response, same as a drained one.
                if (data_addr_ok) begin
                    inc         = 1'b1;
                    resp_valid  = !flush;
                    resp_issued = !flush;
                    state_d     = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (data_addr_ok) begin
                    inc     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dec = data_data_ok && (cnt_q != '0);
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            va_q    <= '0;
            store_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            strb_q  <= '0;
            bdata_q <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            store_q <= store_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            bdata_q <= bdata_d;
        end
    end

    assign tlb_vppn     = va_q[31:13];
    assign tlb_va_bit12 = va_q[12];
    assign data_req     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign data_wr      = store_q;
    assign data_size    = size_q;
    assign data_wstrb   = strb_q;
    assign data_addr    = addr_q;
    assign data_wdata   = bdata_q;
    assign resp_tag     = tag_q;

`ifdef MEM_XLATE_PERF_EN
    logic [31:0] perf_tlb_miss_q, perf_tlb_miss_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_tlb_miss_d = perf_tlb_miss_q;
        perf_stall_d    = perf_stall_q;
        if (state_q == ST_XLATE && !flush && exc[EXC_TLBR] && perf_tlb_miss_q != '1)
            perf_tlb_miss_d = perf_tlb_miss_q + 1'b1;
        if (state_q == ST_ISSUE && !data_addr_ok && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tlb_miss_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_tlb_miss_q <= perf_tlb_miss_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_tlb_miss = perf_tlb_miss_q;
    assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_xlate_issue.sv
// Bench for mem_xlate_issue: vector table plus hand-written sequences for
// outstanding-count limits, flush and reset corner cases.
module tb_mem_xlate_issue;

    localparam int DMW_NUM   = 2;
    localparam int MAX_OUTST = 4;
    localparam int TAG_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_vaddr = '0;
    logic                 in_store = 1'b0;
    logic [1:0]           in_size = '0;
    logic [31:0]          in_wdata = '0;
    logic [TAG_W-1:0]     in_tag = '0;
    logic                 flush = 1'b0;
    logic [1:0]           plv = '0;
    logic                 direct_addr = 1'b0;
    logic [DMW_NUM*8-1:0] dmw_cfg = 16'h4C85; // dmw1: plv3, 4->1; dmw0: plv0, 5->0
    logic [18:0]          tlb_vppn;
    logic                 tlb_va_bit12;
    logic                 tlb_found = 1'b0, tlb_v = 1'b0, tlb_d = 1'b0;
    logic [19:0]          tlb_ppn = '0;
    logic [5:0]           tlb_ps = 6'd12;
    logic [1:0]           tlb_plv = '0;
    logic                 data_req, data_wr;
    logic [1:0]           data_size;
    logic [3:0]           data_wstrb;
    logic [31:0]          data_addr, data_wdata;
    logic                 addr_ok = 1'b0, data_ok = 1'b0;
    logic                 resp_valid, resp_issued;
    logic [TAG_W-1:0]     resp_tag;
    logic [6:0]           resp_exc;
`ifdef MEM_XLATE_PERF_EN
    logic [31:0]          perf_tlb_miss, perf_stall;
`endif

    always #5 clk = ~clk;

    mem_xlate_issue #(.DMW_NUM(DMW_NUM), .MAX_OUTST(MAX_OUTST), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr),
        .in_store(in_store), .in_size(in_size), .in_wdata(in_wdata), .in_tag(in_tag),
        .flush(flush), .plv(plv), .direct_addr(direct_addr), .dmw_cfg(dmw_cfg),
        .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12),
        .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d),
        .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps), .tlb_plv(tlb_plv),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(addr_ok), .data_data_ok(data_ok),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_exc(resp_exc),
        .resp_issued(resp_issued)
`ifdef MEM_XLATE_PERF_EN
        , .perf_tlb_miss(perf_tlb_miss), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] va;   logic st;  logic [1:0] sz; logic [31:0] wd;
        logic [1:0]  plv;  logic dir;
        logic fnd; logic v; logic d; logic [19:0] ppn; logic [5:0] ps; logic [1:0] tplv;
        int          dly;
        logic [6:0]  e_exc; logic e_iss; logic [31:0] e_addr; logic [3:0] e_strb; logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0] tag; logic [6:0] exc; logic iss;
        logic [31:0] addr; logic [3:0] strb; logic [31:0] wd; logic [1:0] sz; logic wr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[15];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every resp_valid pops one expected record.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_unexpected: got resp tag %h exc %b issued %b, required no response",
                         resp_tag, resp_exc, resp_issued);
            end else begin
                e = sb.pop_front();
                chk("resp_tag", 32'(resp_tag), 32'(e.tag));
                chk("resp_exc", 32'(resp_exc), 32'(e.exc));
                chk("resp_issued", 32'(resp_issued), 32'(e.iss));
                if (e.iss) begin
                    chk("data_addr", data_addr, e.addr);
                    chk("data_wstrb", 32'(data_wstrb), 32'(e.strb));
                    chk("data_wdata", data_wdata, e.wd);
                    chk("data_size", 32'(data_size), 32'(e.sz));
                    chk("data_wr", 32'(data_wr), 32'(e.wr));
                end
            end
        end
    end

    // Wait (bounded) for in_ready, present the request for one edge.
    // Returns #1 after the accepting edge, i.e. in the XLATE cycle.
    task automatic drive_req(input vec_t v, input logic [TAG_W-1:0] tag);
        int k;
        plv = v.plv; direct_addr = v.dir;
        tlb_found = v.fnd; tlb_v = v.v; tlb_d = v.d;
        tlb_ppn = v.ppn; tlb_ps = v.ps; tlb_plv = v.tplv;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_vaddr = v.va; in_store = v.st;
        in_size = v.sz; in_wdata = v.wd; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // dok_mode: 0 no data_ok, 1 data_ok the cycle after addr_ok, 2 same cycle.
    task automatic send(input vec_t v, input logic [TAG_W-1:0] tag, input int dok_mode);
        sb.push_back('{tag, v.e_exc, v.e_iss, v.e_addr, v.e_strb, v.e_wd, v.sz, v.st});
        drive_req(v, tag);
        chk("tlb_vppn", 32'(tlb_vppn), 32'(v.va[31:13]));
        chk("tlb_va_bit12", 32'(tlb_va_bit12), 32'(v.va[12]));
        @(posedge clk); #1;
        if (v.e_iss) begin
            repeat (v.dly) begin
                chk("req_hold_addr", data_addr, v.e_addr);
                @(posedge clk); #1;
            end
            chk("data_req_issue", 32'(data_req), 32'd1);
            addr_ok = 1'b1;
            data_ok = (dok_mode == 2);
            @(posedge clk); #1;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            if (dok_mode == 1) begin
                data_ok = 1'b1;
                @(posedge clk); #1;
                data_ok = 1'b0;
            end
        end
        chk("data_req_done", 32'(data_req), 32'd0);
    endtask

    task automatic pulse_dok(input int n);
        repeat (n) begin
            data_ok = 1'b1;
            @(posedge clk); #1;
            data_ok = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          va            st sz  wd            plv dir fnd v d  ppn       ps  tplv dly exc    iss addr          strb  wdata
        tbl[0]  = '{32'hA000_0010,0,2'd2,32'h0,        2'd0,0, 0,0,0, 20'h0,    6'd12,2'd0,3, 7'h00,1,32'h0000_0010,4'hF,32'h0};
        tbl[1]  = '{32'h0000_1003,1,2'd1,32'h5555,     2'd0,0, 0,0,0, 20'h0,    6'd12,2'd0,0, 7'h20,0,32'h0,        4'h0,32'h0};
        tbl[2]  = '{32'h0040_2000,0,2'd2,32'h0,        2'd0,0, 0,0,0, 20'h0,    6'd12,2'd0,0, 7'h10,0,32'h0,        4'h0,32'h0};
        tbl[3]  = '{32'h0040_2004,1,2'd2,32'hDEADBEEF, 2'd0,0, 1,1,0, 20'h00111,6'd12,2'd0,0, 7'h01,0,32'h0,        4'h0,32'h0};
        tbl[4]  = '{32'h1234_5677,1,2'd0,32'h0000_00AB,2'd0,1, 0,0,0, 20'h0,    6'd12,2'd0,0, 7'h00,1,32'h1234_5677,4'h8,32'hABAB_ABAB};
        tbl[5]  = '{32'h8000_1002,1,2'd1,32'h1234_BEEF,2'd3,0, 0,0,0, 20'h0,    6'd12,2'd0,1, 7'h00,1,32'h2000_1002,4'hC,32'hBEEF_BEEF};
        tbl[6]  = '{32'hC000_0000,0,2'd2,32'h0,        2'd3,0, 0,0,0, 20'h0,    6'd12,2'd0,0, 7'h40,0,32'h0,        4'h0,32'h0};
        tbl[7]  = '{32'h0012_3454,0,2'd2,32'h0,        2'd3,0, 1,1,0, 20'hABCDE,6'd12,2'd3,2, 7'h00,1,32'hABCD_E454,4'hF,32'h0};
        tbl[8]  = '{32'h0076_5430,0,2'd2,32'h0,        2'd0,0, 1,1,1, 20'h12345,6'd22,2'd0,0, 7'h00,1,32'h1236_5430,4'hF,32'h0};
        tbl[9]  = '{32'h0040_3000,0,2'd2,32'h0,        2'd3,0, 1,1,1, 20'h00001,6'd12,2'd0,0, 7'h02,0,32'h0,        4'h0,32'h0};
        tbl[10] = '{32'h0040_3000,0,2'd2,32'h0,        2'd0,0, 1,0,1, 20'h00001,6'd12,2'd0,0, 7'h08,0,32'h0,        4'h0,32'h0};
        tbl[11] = '{32'h0040_3000,1,2'd2,32'h1,        2'd0,0, 1,0,0, 20'h00001,6'd12,2'd0,0, 7'h04,0,32'h0,        4'h0,32'h0};
        tbl[12] = '{32'hC000_0000,0,2'd2,32'h0,        2'd3,1, 0,0,0, 20'h0,    6'd12,2'd0,0, 7'h00,1,32'hC000_0000,4'hF,32'h0};
        tbl[13] = '{32'h0000_1000,1,2'd1,32'h0000_5A5A,2'd0,0, 1,1,1, 20'h00ABC,6'd12,2'd3,0, 7'h00,1,32'h00AB_C000,4'h3,32'h5A5A_5A5A};
        tbl[14] = '{32'hA000_0010,0,2'd2,32'h0,        2'd3,0, 1,1,1, 20'h0,    6'd12,2'd0,0, 7'h40,0,32'h0,        4'h0,32'h0};

        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table, each issued request retired by data_ok afterwards
        for (int i = 0; i < 15; i++)
            send(tbl[i], TAG_W'(i), 1);

        // Four outstanding requests close the port; one data_ok reopens it
        for (int i = 0; i < 4; i++)
            send(tbl[4], TAG_W'(i), 0);
        @(posedge clk); #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        pulse_dok(1);
        chk("dok_reopen_in_ready", 32'(in_ready), 32'd1);
        pulse_dok(3);
        pulse_dok(1); // count already 0: must be ignored

        // Simultaneous increment and decrement holds the count
        send(tbl[4], 4'd1, 0);
        send(tbl[4], 4'd2, 2);
        send(tbl[4], 4'd3, 0);
        send(tbl[4], 4'd4, 0);
        chk("three_outst_in_ready", 32'(in_ready), 32'd1);
        send(tbl[4], 4'd5, 0);
        chk("four_outst_in_ready", 32'(in_ready), 32'd0);
        pulse_dok(4);

        // Flush in ISSUE: drain to addr_ok, no response, still counted
        drive_req(tbl[4], 4'd6);
        @(posedge clk); #1;
        flush = 1'b1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("drain_req_held", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        chk("drain_addr_stable", data_addr, 32'h1234_5677);
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        chk("drain_done_req", 32'(data_req), 32'd0);
        for (int i = 0; i < 3; i++)
            send(tbl[4], TAG_W'(8 + i), 0);
        chk("drain_counted_in_ready", 32'(in_ready), 32'd0);
        pulse_dok(4);

        // Flush in XLATE: request dropped silently
        drive_req(tbl[0], 4'd11);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("xlate_flush_req", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        chk("xlate_flush_idle", 32'(in_ready), 32'd1);

        // Reset during ISSUE abandons the request at once
        drive_req(tbl[4], 4'd12);
        @(posedge clk); #1;
        chk("issue_before_rst", 32'(data_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_in_issue_req", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_issue_ready", 32'(in_ready), 32'd1);
        send(tbl[0], 4'd13, 1);

        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
